nios_multi_timer: RTL and testbench

Parametrised multi-channel interval timer on the Nios system's Avalon-MM bus, the successor to the single-channel system timer. It provides NUM_CH independent down-counters of configurable width, each with its own period, snapshot, optional prescaler, one-shot or continuous mode, and a per-channel interrupt. A combined interrupt line also goes to the Nios interrupt controller.

---
 rtl/nios_multi_timer_if.sv | 12 +
 rtl/nios_multi_timer.sv | 134 +++++++++++++
 tb/tb_nios_multi_timer.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/nios_multi_timer_if.sv
// Avalon-MM slave bus bundle for nios_multi_timer: word address, select,
// active-low write strobe and registered read data.
interface nios_multi_timer_if;
  logic [4:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/nios_multi_timer.sv
// Multi-channel Avalon-MM interval timer: NUM_CH down-counters with period,
// snapshot, one-shot/continuous mode and irq. Optional prescaler: NIOS_MULTI_TIMER_PRESCALE_EN.
module nios_multi_timer_ch #(
  parameter int          COUNT_W      = 32,
  parameter int unsigned RESET_PERIOD = 49999
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [2:0]  off,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);
  localparam logic [COUNT_W-1:0] RST_P = COUNT_W'(RESET_PERIOD);

  logic               to, run;
  logic [3:0]         ctrl;
  logic [COUNT_W-1:0] period, count, snap;
  logic               tick, timeout;

  wire wr_status = wr_en & (off == 3'd0);
  wire wr_ctrl   = wr_en & (off == 3'd1);
  wire wr_period = wr_en & (off == 3'd2);
  wire wr_snap   = wr_en & (off == 3'd3);
  wire start     = wr_ctrl & wdata[2];
  wire stop      = wr_ctrl & wdata[3];

`ifdef NIOS_MULTI_TIMER_PRESCALE_EN
  wire wr_pre = wr_en & (off == 3'd4);
  logic [15:0] pre, pcnt;

  assign tick = run & (pcnt == pre);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre  <= '0;
      pcnt <= '0;
    end else begin
      if (wr_pre) pre <= wdata[15:0];
      if (start | wr_period) pcnt <= '0;
      else if (run) pcnt <= (pcnt == pre) ? 16'd0 : pcnt + 16'd1;
    end
  end
`else
  assign tick = run;
`endif

  assign timeout = tick & (count == '0);
  assign irq     = to & ctrl[0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to     <= 1'b0;
      run    <= 1'b0;
      ctrl   <= '0;
      period <= RST_P;
      count  <= RST_P;
      snap   <= '0;
    end else begin
      // a timeout landing on a STATUS write keeps TO set
      if (wr_status) to <= 1'b0;
      if (timeout)   to <= 1'b1;
      if (wr_ctrl)   ctrl <= wdata[3:0];
      if (wr_period) begin
        period <= wdata[COUNT_W-1:0];
        count  <= wdata[COUNT_W-1:0];
      end else if (tick) begin
        count <= timeout ? period : count - COUNT_W'(1);
      end
      if (wr_snap) snap <= count;
      if (start) run <= 1'b1;
      else if (wr_period | stop | (timeout & ~ctrl[1])) run <= 1'b0;
    end
  end

  always_comb begin
    rdata = '0;
    case (off)
      3'd0: rdata = {30'd0, run, to};
      3'd1: rdata = {28'd0, ctrl};
      3'd2: rdata = 32'(period);
      3'd3: rdata = 32'(snap);
`ifdef NIOS_MULTI_TIMER_PRESCALE_EN
      3'd4: rdata = {16'd0, pre};
`endif
      default: rdata = '0;
    endcase
  end
endmodule

module nios_multi_timer #(
  parameter int          NUM_CH       = 2,
  parameter int          COUNT_W      = 32,
  parameter int unsigned RESET_PERIOD = 49999
) (
  input  logic              clk,
  input  logic              reset,
  nios_multi_timer_if.slave bus,
  output logic [NUM_CH-1:0] irq,
  output logic              irq_any
);
  logic [NUM_CH-1:0][31:0] rd_ch;
  logic [NUM_CH-1:0]       wr_ch;
  logic [31:0]             rd_next;
  wire  [1:0]              ch_sel = bus.address[4:3];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign wr_ch[i] = bus.chipselect & ~bus.write_n & (ch_sel == 2'(i));
    nios_multi_timer_ch #(.COUNT_W(COUNT_W), .RESET_PERIOD(RESET_PERIOD)) u_ch (
      .clk   (clk),
      .reset (reset),
      .wr_en (wr_ch[i]),
      .off   (bus.address[2:0]),
      .wdata (bus.writedata),
      .rdata (rd_ch[i]),
      .irq   (irq[i])
    );
  end

  assign irq_any = |irq;

  // channels beyond NUM_CH fall through to zero
  always_comb begin
    rd_next = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (ch_sel == 2'(i)) rd_next = rd_ch[i];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) bus.readdata <= '0;
    else       bus.readdata <= rd_next;
  end
endmodule

// File: tb/tb_nios_multi_timer.sv
// Directed self-checking bench for nios_multi_timer (NUM_CH=2, COUNT_W=32).
module tb_nios_multi_timer;
  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] irq;
  logic       irq_any;
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;

  nios_multi_timer_if bus();

  nios_multi_timer #(.NUM_CH(2), .COUNT_W(32), .RESET_PERIOD(49999)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .irq     (irq),
    .irq_any (irq_any)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // called at a negedge; the write lands on the next posedge
  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    bus.address = a; bus.writedata = d; bus.chipselect = 1'b1; bus.write_n = 1'b0;
    @(negedge clk);
    bus.chipselect = 1'b0; bus.write_n = 1'b1;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    bus.address = a; bus.chipselect = 1'b1; bus.write_n = 1'b1;
    @(negedge clk);
    d = bus.readdata;
    bus.chipselect = 1'b0;
  endtask

  task automatic wait_irq(input int ch, output int t);
    bit found = 0;
    t = -1;
    for (int i = 0; i < 100; i++) begin
      if (irq[ch]) begin found = 1; t = cyc; break; end
      @(negedge clk);
    end
    checks++;
    if (!found) begin failures++; $display("FAIL wait_irq ch%0d: irq never rose within 100 cycles", ch); end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b1;
    bus.address = '0; bus.writedata = '0; bus.chipselect = 1'b0; bus.write_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (bus.readdata !== 32'd0 || irq !== 2'b00 || irq_any !== 1'b0) begin
      failures++; $display("FAIL reset_outputs: rd=%h irq=%b any=%b, want 0", bus.readdata, irq, irq_any); end
    reset = 1'b0;
    @(negedge clk);
    rd(5'h00, d); checks++; if (d !== 32'd0) begin failures++; $display("FAIL reset_status: got %h want 0", d); end
    rd(5'h01, d); checks++; if (d !== 32'd0) begin failures++; $display("FAIL reset_ctrl: got %h want 0", d); end
    rd(5'h0A, d); checks++; if (d !== 32'd49999) begin failures++; $display("FAIL reset_period: got %0d want 49999", d); end
  endtask

  task automatic test_continuous();
    logic [31:0] d;
    wr(5'h02, 32'd3);
    wr(5'h01, 32'h7);
    repeat (3) @(negedge clk);
    checks++; if (irq[0] !== 1'b0) begin failures++; $display("FAIL cont_early: irq0=%b want 0", irq[0]); end
    @(negedge clk);
    checks++; if (irq[0] !== 1'b1 || irq_any !== 1'b1) begin
      failures++; $display("FAIL cont_first: irq0=%b any=%b want 1 1", irq[0], irq_any); end
    wr(5'h00, 32'd0);
    checks++; if (irq[0] !== 1'b0) begin failures++; $display("FAIL cont_clear: irq0=%b want 0", irq[0]); end
    repeat (2) @(negedge clk);
    checks++; if (irq[0] !== 1'b0) begin failures++; $display("FAIL cont_second_early: irq0=%b want 0", irq[0]); end
    @(negedge clk);
    checks++; if (irq[0] !== 1'b1) begin failures++; $display("FAIL cont_second: irq0=%b want 1", irq[0]); end
    rd(5'h00, d); checks++; if (d !== 32'd3) begin failures++; $display("FAIL cont_status: got %h want 3", d); end
    // next zero-tick coincides with the write issued two cycles on
    repeat (2) @(negedge clk);
    wr(5'h00, 32'd0);
    checks++; if (irq[0] !== 1'b1) begin failures++; $display("FAIL collision_keep: irq0=%b want 1", irq[0]); end
    wr(5'h00, 32'd0);
    checks++; if (irq[0] !== 1'b0) begin failures++; $display("FAIL collision_late_clear: irq0=%b want 0", irq[0]); end
    wr(5'h01, 32'h8);
  endtask

  task automatic test_start_stop();
    logic [31:0] d;
    wr(5'h01, 32'hC);
    rd(5'h00, d); checks++; if (d[1] !== 1'b1) begin failures++; $display("FAIL start_beats_stop: run=%b want 1", d[1]); end
    rd(5'h01, d); checks++; if (d !== 32'hC) begin failures++; $display("FAIL ctrl_readback: got %h want c", d); end
    wr(5'h01, 32'h8);
    rd(5'h00, d); checks++; if (d[1] !== 1'b0) begin failures++; $display("FAIL stop: run=%b want 0", d[1]); end
    wr(5'h00, 32'd0);
  endtask

  task automatic test_oneshot();
    logic [31:0] d;
    wr(5'h0A, 32'd2);
    wr(5'h09, 32'h5);
    repeat (2) @(negedge clk);
    checks++; if (irq[1] !== 1'b0) begin failures++; $display("FAIL oneshot_early: irq1=%b want 0", irq[1]); end
    @(negedge clk);
    checks++; if (irq !== 2'b10 || irq_any !== 1'b1) begin
      failures++; $display("FAIL oneshot_irq: irq=%b any=%b want 10 1", irq, irq_any); end
    rd(5'h08, d); checks++; if (d !== 32'd1) begin failures++; $display("FAIL oneshot_status: got %h want 1", d); end
    wr(5'h0B, 32'd0);
    rd(5'h0B, d); checks++; if (d !== 32'd2) begin failures++; $display("FAIL oneshot_count: got %0d want 2", d); end
    wr(5'h08, 32'd0);
  endtask

  task automatic test_snapshot();
    logic [31:0] d;
    wr(5'h02, 32'd100);
    wr(5'h01, 32'h6);
    repeat (9) @(negedge clk);
    wr(5'h03, 32'd0);
    rd(5'h03, d); checks++; if (d !== 32'd91) begin failures++; $display("FAIL snap_value: got %0d want 91", d); end
    wr(5'h02, 32'd50);
    wr(5'h03, 32'd0);
    rd(5'h03, d); checks++; if (d !== 32'd50) begin failures++; $display("FAIL period_reload: count=%0d want 50", d); end
    rd(5'h00, d); checks++; if (d[1] !== 1'b0) begin failures++; $display("FAIL period_stops: run=%b want 0", d[1]); end
    wr(5'h00, 32'd0);
  endtask

  task automatic test_prescale();
    logic [31:0] d;
    int t0, t1, t2, exp_p, exp_r;
`ifdef NIOS_MULTI_TIMER_PRESCALE_EN
    exp_p = 6; exp_r = 1;
`else
    exp_p = 3; exp_r = 0;
`endif
    wr(5'h02, 32'd2);
    wr(5'h04, 32'd1);
    wr(5'h01, 32'h7);
    t0 = cyc;
    wait_irq(0, t1);
    wr(5'h00, 32'd0);
    wait_irq(0, t2);
    checks++; if (t1 - t0 !== exp_p) begin failures++; $display("FAIL pre_first: %0d clocks want %0d", t1 - t0, exp_p); end
    checks++; if (t2 - t1 !== exp_p) begin failures++; $display("FAIL pre_period: %0d clocks want %0d", t2 - t1, exp_p); end
    rd(5'h04, d); checks++; if (d !== exp_r) begin failures++; $display("FAIL pre_read: got %0d want %0d", d, exp_r); end
    wr(5'h01, 32'h8);
    wr(5'h00, 32'd0);
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    int t;
    wr(5'h0A, 32'd8);
    wr(5'h09, 32'h7);
    wait_irq(1, t);
    repeat (2) @(negedge clk);
    bus.address = 5'h08;
    @(negedge clk);
    checks++; if (bus.readdata !== 32'd3) begin failures++; $display("FAIL mid_pre_status: got %h want 3", bus.readdata); end
    #2 reset = 1'b1;
    #1;
    checks++; if (bus.readdata !== 32'd0 || irq !== 2'b00 || irq_any !== 1'b0) begin
      failures++; $display("FAIL mid_async: rd=%h irq=%b any=%b want 0", bus.readdata, irq, irq_any); end
    @(negedge clk);
    reset = 1'b0;
    rd(5'h08, d); checks++; if (d !== 32'd0) begin failures++; $display("FAIL mid_status: got %h want 0", d); end
    wr(5'h0B, 32'd0);
    rd(5'h0B, d); checks++; if (d !== 32'd49999) begin failures++; $display("FAIL mid_count: got %0d want 49999", d); end
  endtask

  task automatic test_unmapped();
    logic [31:0] d;
    wr(5'h1A, 32'd5);
    rd(5'h1A, d); checks++; if (d !== 32'd0) begin failures++; $display("FAIL ch3_read: got %h want 0", d); end
    wr(5'h05, 32'hFFFF_FFFF);
    rd(5'h05, d); checks++; if (d !== 32'd0) begin failures++; $display("FAIL off5_read: got %h want 0", d); end
    rd(5'h02, d); checks++; if (d !== 32'd49999) begin failures++; $display("FAIL ch0_period_intact: got %0d want 49999", d); end
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_start_stop();
    test_oneshot();
    test_snapshot();
    test_prescale();
    test_reset_mid();
    test_unmapped();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
